ddr3_rst_seq: RTL



---
 rtl/ddr3_rst_seq.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_rst_seq
// Purpose  : Reset / bring-up sequencer placed after the DDR3 PLL wrapper.
//            Pulses the PLL reset, waits for lock and qualifies it as stable.
//            It then releases the DDR3 controller reset, supervises
//            calibration and finally releases the system reset. Lock
//            timeout, calibration timeout or lock loss start a new attempt.
//            After too many failed attempts the block parks in FAIL.
// Ports    : clk             free-running PLL init clock
//            rst_n           asynchronous active-low reset
//            pll_lock_i      PLL lock (asynchronous, synchronized here)
//            ddr_init_done_i DDR3 calibration done (asynchronous, synced)
//            sw_rst_req_i    one-cycle synchronous request to restart
//            pll_rst_o       PLL reset request, active high
//            ddr_rst_n_o     DDR3 controller reset, active low
//            sys_rst_n_o     system reset, active low
//            ready_o         bring-up complete
//            fail_o          retries exhausted
//            retry_cnt_o     failed attempts since last clean start (sat 15)
// Revision : 1.0  initial release
// ============================================================================
module ddr3_rst_seq #(
  parameter int SYNC_STAGES      = 2,
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int DDR_HOLD_CYC     = 64,
  parameter int CAL_TIMEOUT_CYC  = 262144,
  parameter int RETRY_MAX        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock_i,
  input  logic       ddr_init_done_i,
  input  logic       sw_rst_req_i,
  output logic       pll_rst_o,
  output logic       ddr_rst_n_o,
  output logic       sys_rst_n_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o
);

  // Fewer than two synchronizer flops is never safe, so clamp.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // Timer must hold the largest terminal count of any state.
  localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CD  = (LOCK_STABLE_CYC > DDR_HOLD_CYC) ? LOCK_STABLE_CYC : DDR_HOLD_CYC;
  localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_CYC = (MAX_ABC > CAL_TIMEOUT_CYC) ? MAX_ABC : CAL_TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  // The timer reads 0 in the first cycle of a state, so a state that must
  // last N cycles exits when the timer shows N-1.
  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(DDR_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] CAL_LAST    = TMR_W'(CAL_TIMEOUT_CYC - 1);
  localparam logic [31:0]      RETRY_LIM   = 32'(RETRY_MAX);

  localparam logic [2:0] S_RST_PLL   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_DDR_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT_CAL  = 3'd4;
  localparam logic [2:0] S_RUN       = 3'd5;
  localparam logic [2:0] S_FAIL      = 3'd6;

  // --------------------------------------------------------------------------
  // Input synchronizers
  // --------------------------------------------------------------------------
  logic [SYNC_N-1:0] lock_sync_q;
  logic [SYNC_N-1:0] done_sync_q;
  logic              lock_s;
  logic              done_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= '0;
      done_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_N-2:0], pll_lock_i};
      done_sync_q <= {done_sync_q[SYNC_N-2:0], ddr_init_done_i};
    end
  end

  assign lock_s = lock_sync_q[SYNC_N-1];
  assign done_s = done_sync_q[SYNC_N-1];

  // --------------------------------------------------------------------------
  // State, timer, retry counter and registered outputs
  // --------------------------------------------------------------------------
  logic [2:0]       state_q,     state_d;
  logic [TMR_W-1:0] timer_q,     timer_d;
  logic [3:0]       retry_q,     retry_d;
  logic             pll_rst_q,   pll_rst_d;
  logic             ddr_rst_n_q, ddr_rst_n_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q,     ready_d;
  logic             fail_q,      fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST_PLL;
      timer_q     <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      ddr_rst_n_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      ddr_rst_n_q <= ddr_rst_n_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic       retry_evt;
  logic [3:0] retry_inc;
  logic       restart;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_evt = 1'b0;
    retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    // Lock loss is tested before timer expiry everywhere, which gives it
    // priority when both happen in the same cycle.
    case (state_q)
      S_RST_PLL: begin
        if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s)                  state_d   = S_STABLE;
        else if (timer_q == LOCK_LAST) retry_evt = 1'b1;
      end
      S_STABLE: begin
        // A dropout here only restarts qualification, not a new attempt.
        if (!lock_s)                     state_d = S_WAIT_LOCK;
        else if (timer_q == STABLE_LAST) state_d = S_DDR_HOLD;
      end
      S_DDR_HOLD: begin
        if (!lock_s)                   retry_evt = 1'b1;
        else if (timer_q == HOLD_LAST) state_d   = S_WAIT_CAL;
      end
      S_WAIT_CAL: begin
        if (!lock_s)                  retry_evt = 1'b1;
        else if (done_s)              state_d   = S_RUN;
        else if (timer_q == CAL_LAST) retry_evt = 1'b1;
      end
      S_RUN: begin
        if (!lock_s) retry_evt = 1'b1;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RST_PLL;
      end
    endcase

    if (retry_evt) begin
      retry_d = retry_inc;
      state_d = ({28'd0, retry_inc} >= RETRY_LIM) ? S_FAIL : S_RST_PLL;
    end

    // Software restart overrides everything decided above.
    if (sw_rst_req_i) begin
      state_d = S_RST_PLL;
      retry_d = '0;
    end

    // A software restart re-enters RST_PLL even from RST_PLL, so the
    // pulse always runs its full length.
    restart = sw_rst_req_i || (state_d != state_q);
    if (restart)                timer_d = '0;
    else if (timer_q == '1)     timer_d = timer_q;
    else                        timer_d = timer_q + 1'b1;
  end

  // --------------------------------------------------------------------------
  // Output decode from the next state, so outputs change on the same edge
  // as the state register.
  // --------------------------------------------------------------------------
  always_comb begin
    pll_rst_d   = 1'b0;
    ddr_rst_n_d = 1'b0;
    sys_rst_n_d = 1'b0;
    ready_d     = 1'b0;
    fail_d      = 1'b0;
    case (state_d)
      S_RST_PLL:  pll_rst_d   = 1'b1;
      S_WAIT_CAL: ddr_rst_n_d = 1'b1;
      S_RUN: begin
        ddr_rst_n_d = 1'b1;
        sys_rst_n_d = 1'b1;
        ready_d     = 1'b1;
      end
      S_FAIL: begin
        pll_rst_d = 1'b1;
        fail_d    = 1'b1;
      end
      default: pll_rst_d = 1'b0;
    endcase
  end

  assign pll_rst_o   = pll_rst_q;
  assign ddr_rst_n_o = ddr_rst_n_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign ready_o     = ready_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;

endmodule
`default_nettype wire
